filter_index_seq: RTL and testbench

Parametrised filter/kernel-position index sequencer with a valid/ready output stream. After `start` it walks every kernel position (`state_idx`) of every filter (`filter_idx`), one beat per handshake, and presents a derived address per beat. Stalls on back-pressure, supports abort, and pulses `done` at the end. It replaces the free-running filter-FSM/counter/adder arrangement in the filter datapath front-end.

---
 rtl/filter_index_seq.sv | 118 +++++++++++
 tb/tb_filter_index_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_index_seq.sv
// Filter / kernel-position index sequencer with a valid/ready beat stream.
// Walks every state_idx of every filter_idx once per run and derives an address per beat.
module filter_index_seq #(
    parameter int unsigned N_STATES  = 9,
    parameter int unsigned N_FILTERS = 16,
    parameter int unsigned SW        = 4,
    parameter int unsigned FW        = 8,
    parameter int unsigned AW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic          abort,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [SW-1:0] state_idx,
    output logic [FW-1:0] filter_idx,
    output logic [AW-1:0] addr,
    output logic          last_state,
    output logic          last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    localparam logic [SW-1:0] S_LAST = SW'(N_STATES - 1);
    localparam logic [FW-1:0] F_LAST = FW'(N_FILTERS - 1);
    localparam logic [AW-1:0] NS_A   = AW'(N_STATES);

    fsm_t          state_q, state_d;
    logic [SW-1:0] sidx_q, sidx_d;
    logic [FW-1:0] fidx_q, fidx_d;
    logic          mode_q, mode_d;

    logic          at_s_last;
    logic          at_f_last;
    logic [AW-1:0] f_a;
    logic [AW-1:0] s_a;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sidx_q  <= '0;
            fidx_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sidx_q  <= sidx_d;
            fidx_q  <= fidx_d;
            mode_q  <= mode_d;
        end
    end

    assign at_s_last = (sidx_q == S_LAST);
    assign at_f_last = (fidx_q == F_LAST);

    always_comb begin
        state_d = state_q;
        sidx_d  = sidx_q;
        fidx_d  = fidx_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                sidx_d = '0;
                fidx_d = '0;
                if (start) begin
                    state_d = RUN;
                    mode_d  = mode;
                end
            end
            RUN: begin
                // abort outranks a coincident handshake: that beat is dropped
                if (abort) begin
                    state_d = IDLE;
                    sidx_d  = '0;
                    fidx_d  = '0;
                end else if (out_ready) begin
                    if (at_s_last && at_f_last) begin
                        state_d = DONE;
                        sidx_d  = '0;
                        fidx_d  = '0;
                    end else if (at_s_last) begin
                        sidx_d = '0;
                        fidx_d = fidx_q + FW'(1);
                    end else begin
                        sidx_d = sidx_q + SW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only; out_ready never reaches them.
    assign out_valid  = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign state_idx  = sidx_q;
    assign filter_idx = fidx_q;
    assign last_state = out_valid & at_s_last;
    assign last       = out_valid & at_s_last & at_f_last;

    assign f_a  = AW'(fidx_q);
    assign s_a  = AW'(sidx_q);
    assign addr = mode_q ? (f_a * NS_A + s_a) : (f_a + s_a);

endmodule

// File: tb/tb_filter_index_seq.sv
// Randomised scoreboard bench for filter_index_seq: three instances (9x16 sum,
// 9x32 linear, 1x1 degenerate) checked against a beat-list model.
module tb_filter_index_seq;

    typedef struct {
        int s;
        int f;
        int a;
        bit ls;
        bit l;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic start_a = 1'b0, mode_a = 1'b0, abort_a = 1'b0, ready_a = 1'b1;
    logic start_b = 1'b0, mode_b = 1'b0, abort_b = 1'b0, ready_b = 1'b1;
    logic start_c = 1'b0, mode_c = 1'b0, abort_c = 1'b0, ready_c = 1'b1;

    logic       valid_a, ls_a, l_a, busy_a, done_a;
    logic [3:0] sidx_a;
    logic [7:0] fidx_a, addr_a;
    logic       valid_b, ls_b, l_b, busy_b, done_b;
    logic [3:0] sidx_b;
    logic [7:0] fidx_b, addr_b;
    logic       valid_c, ls_c, l_c, busy_c, done_c;
    logic [0:0] sidx_c, fidx_c;
    logic [3:0] addr_c;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    beat_t qa[$];
    beat_t qb[$];
    beat_t qc[$];
    bit    stall[3];
    beat_t snap[3];
    bit    dexp[3];
    int    prev_hs[3];
    bit    rep_mode = 1'b0;
    string nm[3] = '{"A", "B", "C"};

    filter_index_seq #(.N_STATES(9), .N_FILTERS(16), .SW(4), .FW(8), .AW(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .abort(abort_a),
        .out_ready(ready_a), .out_valid(valid_a), .state_idx(sidx_a), .filter_idx(fidx_a),
        .addr(addr_a), .last_state(ls_a), .last(l_a), .busy(busy_a), .done(done_a)
    );

    filter_index_seq #(.N_STATES(9), .N_FILTERS(32), .SW(4), .FW(8), .AW(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .abort(abort_b),
        .out_ready(ready_b), .out_valid(valid_b), .state_idx(sidx_b), .filter_idx(fidx_b),
        .addr(addr_b), .last_state(ls_b), .last(l_b), .busy(busy_b), .done(done_b)
    );

    filter_index_seq #(.N_STATES(1), .N_FILTERS(1), .SW(1), .FW(1), .AW(4)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .mode(mode_c), .abort(abort_c),
        .out_ready(ready_c), .out_valid(valid_c), .state_idx(sidx_c), .filter_idx(fidx_c),
        .addr(addr_c), .last_state(ls_c), .last(l_c), .busy(busy_c), .done(done_c)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string n, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", n, got, want, cyc);
        end
    endtask

    // Reference: beat k of a run is kernel position k%ns of filter k/ns.
    task automatic push_run(input int id, input int ns, input int nf, input int aw, input bit md);
        beat_t b;
        for (int k = 0; k < ns * nf; k++) begin
            b.s  = k % ns;
            b.f  = k / ns;
            b.a  = (md ? k : (k % ns) + (k / ns)) % (1 << aw);
            b.ls = ((k % ns) == ns - 1);
            b.l  = (k == ns * nf - 1);
            case (id)
                0: qa.push_back(b);
                1: qb.push_back(b);
                default: qc.push_back(b);
            endcase
        end
    endtask

    function automatic int qsize(input int id);
        case (id)
            0: return qa.size();
            1: return qb.size();
            default: return qc.size();
        endcase
    endfunction

    function automatic beat_t qpop(input int id);
        case (id)
            0: return qa.pop_front();
            1: return qb.pop_front();
            default: return qc.pop_front();
        endcase
    endfunction

    function automatic bit valid_of(input int id);
        case (id)
            0: return valid_a;
            1: return valid_b;
            default: return valid_c;
        endcase
    endfunction

    function automatic bit done_of(input int id);
        case (id)
            0: return done_a;
            1: return done_b;
            default: return done_c;
        endcase
    endfunction

    task automatic drive(input int id, input logic st, input logic md, input logic ab, input logic rd);
        case (id)
            0: begin start_a = st; mode_a = md; abort_a = ab; ready_a = rd; end
            1: begin start_b = st; mode_b = md; abort_b = ab; ready_b = rd; end
            default: begin start_c = st; mode_c = md; abort_c = ab; ready_c = rd; end
        endcase
    endtask

    task automatic mon(input int id, input logic v, input logic r, input logic ab,
                       input logic dn, input logic bs, input logic ls, input logic l,
                       input int s, input int f, input int a);
        beat_t e;
        chk({nm[id], "_done"}, int'(dn), int'(dexp[id]));
        chk({nm[id], "_busy"}, int'(bs), int'(v));
        dexp[id] = 1'b0;
        if (v) begin
            if (stall[id]) begin
                chk({nm[id], "_hold_state"}, s, snap[id].s);
                chk({nm[id], "_hold_filter"}, f, snap[id].f);
                chk({nm[id], "_hold_addr"}, a, snap[id].a);
                chk({nm[id], "_hold_last"}, int'(l), int'(snap[id].l));
            end
            if (r && !ab) begin
                if (qsize(id) == 0) begin
                    chk({nm[id], "_unexpected_beat"}, 1, 0);
                end else begin
                    e = qpop(id);
                    chk({nm[id], "_state_idx"}, s, e.s);
                    chk({nm[id], "_filter_idx"}, f, e.f);
                    chk({nm[id], "_addr"}, a, e.a);
                    chk({nm[id], "_last_state"}, int'(ls), int'(e.ls));
                    chk({nm[id], "_last"}, int'(l), int'(e.l));
                    dexp[id] = e.l;
                    if (rep_mode && id == 2 && prev_hs[id] >= 0)
                        chk("C_repeat_period", cyc - prev_hs[id], 3);
                    prev_hs[id] = cyc;
                end
            end
            stall[id] = !r && !ab;
            snap[id]  = '{s, f, a, ls, l};
        end else begin
            stall[id] = 1'b0;
            chk({nm[id], "_idle_state"}, s, 0);
            chk({nm[id], "_idle_filter"}, f, 0);
            chk({nm[id], "_idle_addr"}, a, 0);
            chk({nm[id], "_idle_last"}, int'(ls | l), 0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                stall[i] = 1'b0;
                dexp[i]  = 1'b0;
            end
        end else begin
            mon(0, valid_a, ready_a, abort_a, done_a, busy_a, ls_a, l_a, int'(sidx_a), int'(fidx_a), int'(addr_a));
            mon(1, valid_b, ready_b, abort_b, done_b, busy_b, ls_b, l_b, int'(sidx_b), int'(fidx_b), int'(addr_b));
            mon(2, valid_c, ready_c, abort_c, done_c, busy_c, ls_c, l_c, int'(sidx_c), int'(fidx_c), int'(addr_c));
        end
    end

    // Issue start (optionally with abort) while idle; first beat must appear next cycle.
    task automatic start_run(input int id, input bit md, input bit ab,
                             input int ns, input int nf, input int aw);
        drive(id, 1'b1, md, ab, 1'b1);
        push_run(id, ns, nf, aw, md);
        @(posedge clk);
        #1;
        drive(id, 1'b0, 1'($urandom % 2), 1'b0, 1'b1);
        chk({nm[id], "_start_latency"}, int'(valid_of(id)), 1);
    endtask

    // Run to completion; with bp, ready is random and stray start/mode toggles are injected mid-run.
    task automatic run_wait(input int id, input bit bp, input int budget);
        int n = 0;
        while (!(qsize(id) == 0 && !valid_of(id) && !done_of(id))) begin
            if (n >= budget) begin
                chk({nm[id], "_run_timeout"}, 1, 0);
                case (id)
                    0: qa.delete();
                    1: qb.delete();
                    default: qc.delete();
                endcase
                break;
            end
            @(posedge clk);
            #1;
            n++;
            drive(id, 1'(bp && qsize(id) >= 2 && ($urandom % 8 == 0)), 1'($urandom % 2), 1'b0,
                  bp ? 1'($urandom % 2) : 1'b1);
        end
        drive(id, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) prev_hs[i] = -1;
        #1;
        chk("reset_valid", int'(valid_a), 0);
        chk("reset_busy", int'(busy_a), 0);
        chk("reset_done", int'(done_a), 0);
        chk("reset_addr", int'(addr_a), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // full sweep, sum mode, no stalls
        start_run(0, 1'b0, 1'b0, 9, 16, 8);
        run_wait(0, 1'b0, 1000);

        // back-pressure with stray starts during RUN
        start_run(0, 1'b0, 1'b0, 9, 16, 8);
        run_wait(0, 1'b1, 3000);

        // abort coincident with the handshake of beat 20
        start_run(0, 1'b0, 1'b0, 9, 16, 8);
        repeat (20) @(posedge clk);
        #1 abort_a = 1'b1;
        @(posedge clk);
        #1 abort_a = 1'b0;
        chk("A_abort_beats_left", qa.size(), 144 - 20);
        chk("A_abort_valid", int'(valid_a), 0);
        chk("A_abort_state_idx", int'(sidx_a), 0);
        chk("A_abort_filter_idx", int'(fidx_a), 0);
        qa.delete();
        repeat (4) @(posedge clk);
        #1;
        start_run(0, 1'b0, 1'b0, 9, 16, 8);
        run_wait(0, 1'b0, 1000);

        // asynchronous reset mid-run
        start_run(0, 1'b0, 1'b0, 9, 16, 8);
        repeat (30) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("A_rst_valid", int'(valid_a), 0);
        chk("A_rst_busy", int'(busy_a), 0);
        chk("A_rst_done", int'(done_a), 0);
        chk("A_rst_state_idx", int'(sidx_a), 0);
        chk("A_rst_filter_idx", int'(fidx_a), 0);
        chk("A_rst_addr", int'(addr_a), 0);
        qa.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // linear mode with address wrap; start together with abort in IDLE
        start_run(1, 1'b1, 1'b1, 9, 32, 8);
        run_wait(1, 1'b0, 1000);
        start_run(1, 1'b1, 1'b0, 9, 32, 8);
        run_wait(1, 1'b1, 3000);

        // degenerate single-beat runs
        start_run(2, 1'b0, 1'b0, 1, 1, 4);
        run_wait(2, 1'b0, 100);
        rep_mode   = 1'b1;
        prev_hs[2] = -1;
        drive(2, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int r = 0; r < 5; r++) push_run(2, 1, 1, 4, 1'b0);
        repeat (13) @(posedge clk);
        #1 drive(2, 1'b0, 1'b0, 1'b0, 1'b1);
        run_wait(2, 1'b0, 100);
        repeat (3) @(posedge clk);
        #1 rep_mode = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
